// File: rtl/rx_fifo_sync.sv
// Receive FIFO between the UART receiver and the host reader: circular buffer with
// exact full/empty, fill threshold, sticky overflow, flush, occupancy count and BIST freeze.
module rx_fifo_sync #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_BITS-1:0]  Rx_Data,
    input  logic                  Data_Rdy,
    input  logic                  Pop_Data,
    input  logic                  Flush,
    input  logic                  BIST_Mode,
    input  logic [FIFO_WIDTH:0]   Thresh,
    output logic [DATA_BITS-1:0]  Data_Out,
    output logic                  Data_Valid,
    output logic                  FIFO_Empty,
    output logic                  FIFO_Full,
    output logic                  FIFO_Thresh,
    output logic                  FIFO_Overflow,
    output logic [FIFO_WIDTH:0]   Count
);

    localparam int unsigned DEPTH = 1 << FIFO_WIDTH;
    localparam int unsigned CW    = FIFO_WIDTH + 1;

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [FIFO_WIDTH-1:0] wptr;
    logic [FIFO_WIDTH-1:0] rptr;

    logic          active;
    logic          flush_ok;
    logic          pop_ok;
    logic          push_ok;
    logic          push_drop;
    logic [CW-1:0] count_nxt;

    // Request qualification; BIST freezes everything, flush shadows push/pop.
    always_comb begin
        active    = !BIST_Mode;
        flush_ok  = active && Flush;
        pop_ok    = active && !Flush && Pop_Data && (Count != '0);
        push_ok   = active && !Flush && Data_Rdy && ((Count != CW'(DEPTH)) || pop_ok);
        push_drop = active && !Flush && Data_Rdy && !push_ok;
        count_nxt = Count;
        if (flush_ok) begin
            count_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            count_nxt = Count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = Count - CW'(1);
        end
    end

    // Storage array carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= Rx_Data;
        end
    end

    // Pointers, count, read data and flags registered from the post-edge count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            Count         <= '0;
            Data_Out      <= '0;
            Data_Valid    <= 1'b0;
            FIFO_Empty    <= 1'b1;
            FIFO_Full     <= 1'b0;
            FIFO_Thresh   <= 1'b0;
            FIFO_Overflow <= 1'b0;
        end else begin
            Count       <= count_nxt;
            Data_Valid  <= pop_ok;
            FIFO_Empty  <= (count_nxt == '0);
            FIFO_Full   <= (count_nxt == CW'(DEPTH));
            FIFO_Thresh <= (Thresh != '0) && (count_nxt >= Thresh);
            if (flush_ok) begin
                wptr          <= '0;
                rptr          <= '0;
                Data_Out      <= '0;
                FIFO_Overflow <= 1'b0;
            end else begin
                if (push_ok) begin
                    wptr <= wptr + FIFO_WIDTH'(1);
                end
                if (pop_ok) begin
                    rptr          <= rptr + FIFO_WIDTH'(1);
                    Data_Out      <= mem[rptr];
                    FIFO_Overflow <= 1'b0;
                end else if (push_drop) begin
                    FIFO_Overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_fifo_sync.sv
// Randomised and directed bench for rx_fifo_sync: a queue-based reference model feeds
// expected flags and popped characters to a scoreboard monitor.
module tb_rx_fifo_sync;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Rx_Data;
    logic       Data_Rdy, Pop_Data, Flush, BIST_Mode;
    logic [4:0] Thresh;
    logic [7:0] Data_Out;
    logic       Data_Valid, FIFO_Empty, FIFO_Full, FIFO_Thresh, FIFO_Overflow;
    logic [4:0] Count;

    rx_fifo_sync #(.DATA_BITS(8), .FIFO_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .Rx_Data(Rx_Data), .Data_Rdy(Data_Rdy), .Pop_Data(Pop_Data),
        .Flush(Flush), .BIST_Mode(BIST_Mode), .Thresh(Thresh), .Data_Out(Data_Out),
        .Data_Valid(Data_Valid), .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full),
        .FIFO_Thresh(FIFO_Thresh), .FIFO_Overflow(FIFO_Overflow), .Count(Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] cnt;
        logic       empty, full, thr, ovf, valid;
        logic [7:0] dout;
    } exp_t;

    exp_t       flag_q[$];
    logic [7:0] data_q[$];
    logic [7:0] mq[$];
    logic       ovf_m;
    logic [7:0] dout_m;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model computes the expected outcome of the coming edge.
    task automatic step(input bit push, input bit pop, input bit flush, input bit bist,
                        input logic [7:0] d, input logic [4:0] thr);
        exp_t e;
        bit   pop_ok, push_ok;
        @(negedge clk);
        Data_Rdy = push; Pop_Data = pop; Flush = flush; BIST_Mode = bist;
        Rx_Data = d; Thresh = thr;
        e.valid = 1'b0;
        if (!bist) begin
            if (flush) begin
                mq.delete();
                ovf_m  = 1'b0;
                dout_m = 8'h00;
            end else begin
                pop_ok  = pop && (mq.size() > 0);
                push_ok = push && ((mq.size() < DEPTH) || pop_ok);
                if (pop_ok) begin
                    dout_m = mq.pop_front();
                    data_q.push_back(dout_m);
                    e.valid = 1'b1;
                    ovf_m   = 1'b0;
                end
                if (push_ok) mq.push_back(d);
                else if (push) ovf_m = 1'b1;
            end
        end
        e.cnt   = 5'(mq.size());
        e.empty = (mq.size() == 0);
        e.full  = (mq.size() == DEPTH);
        e.thr   = (thr != 0) && (mq.size() >= int'(thr));
        e.ovf   = ovf_m;
        e.dout  = dout_m;
        flag_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [4:0] thr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, thr);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(Count), 32'd0);
        chk({tag, "_empty"}, 32'(FIFO_Empty), 32'd1);
        chk({tag, "_full"}, 32'(FIFO_Full), 32'd0);
        chk({tag, "_ovf"}, 32'(FIFO_Overflow), 32'd0);
        chk({tag, "_dout"}, 32'(Data_Out), 32'd0);
        chk({tag, "_valid"}, 32'(Data_Valid), 32'd0);
        chk({tag, "_thr"}, 32'(FIFO_Thresh), 32'd0);
    endtask

    // Scoreboard monitor: compares every registered result just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (flag_q.size() > 0) begin
                e = flag_q.pop_front();
                chk("count", 32'(Count), 32'(e.cnt));
                chk("empty", 32'(FIFO_Empty), 32'(e.empty));
                chk("full", 32'(FIFO_Full), 32'(e.full));
                chk("thresh", 32'(FIFO_Thresh), 32'(e.thr));
                chk("overflow", 32'(FIFO_Overflow), 32'(e.ovf));
                chk("valid", 32'(Data_Valid), 32'(e.valid));
                chk("data_out_hold", 32'(Data_Out), 32'(e.dout));
            end
            if (Data_Valid === 1'b1) begin
                if (data_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_data: got unexpected Data_Valid with %0h, required none", Data_Out);
                end else begin
                    chk("pop_data", 32'(Data_Out), 32'(data_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int  budget;
        logic [4:0] thr_r;
        rst = 1'b1; Rx_Data = '0; Data_Rdy = 0; Pop_Data = 0; Flush = 0; BIST_Mode = 0; Thresh = '0;
        ovf_m = 1'b0; dout_m = 8'h00;
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill to full and drain in order.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i), 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00, 0);
        // Overflow on push while full, cleared by the next pop.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i), 0);
        step(1, 0, 0, 0, 8'hAA, 0);
        step(0, 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 8'h00, 0);
        // Threshold at 5, then disabled.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'h40 + i), 5'd5);
        step(0, 1, 0, 0, 8'h00, 5'd5);
        step(1, 0, 0, 0, 8'h50, 5'd5);
        idle(2, 5'd0);
        idle(1, 5'd17);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00, 0);
        // Simultaneous push/pop when full, and when empty.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h80 + i), 0);
        step(1, 0, 0, 0, 8'hEE, 0);
        step(1, 1, 0, 0, 8'h55, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00, 0);
        step(1, 1, 0, 0, 8'h33, 0);
        step(0, 1, 0, 0, 8'h00, 0);
        // Pointer wrap, flush, BIST freeze.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 8'(8'hC0 + i), 0);
            step(0, 1, 0, 0, 8'h00, 0);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(8'h10 + i), 0);
        step(1, 1, 1, 0, 8'h77, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h20 + i), 0);
        step(1, 0, 0, 1, 8'h99, 0);
        step(0, 1, 0, 1, 8'h00, 0);
        step(1, 1, 1, 1, 8'h98, 0);
        step(0, 1, 0, 0, 8'h00, 0);
        idle(1, 0);
        // Asynchronous reset between edges.
        step(1, 0, 0, 0, 8'h61, 0);
        step(1, 0, 0, 0, 8'h62, 0);
        @(negedge clk);
        Data_Rdy = 0; Pop_Data = 0; Flush = 0; BIST_Mode = 0;
        rst = 1'b1;
        #1;
        check_reset_vals("async_reset");
        mq.delete(); data_q.delete(); ovf_m = 1'b0; dout_m = 8'h00;
        #2;
        rst = 1'b0;

        // Random traffic with varying threshold.
        thr_r = 5'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) thr_r = 5'($urandom_range(0, 18));
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                 8'($urandom), thr_r);
        end
        idle(3, thr_r);

        budget = 20;
        while ((flag_q.size() > 0) && (budget > 0)) begin
            @(posedge clk);
            budget--;
        end
        #5;
        chk("scoreboard_drained", 32'(flag_q.size() + data_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
